// File: rtl/pre_map_pipe_pkg.sv
// pre_map_pipe_pkg: shared bias-select enum, decode record and exponent-limit helpers.
package pre_map_pipe_pkg;
  typedef enum logic [2:0] {BS_NONE, BS_B1, BS_B2, BS_B3, BS_B4} bsel_t;
  typedef struct packed {
    logic  fast;
    logic  mode;
    logic  sign;
    logic  op;
    bsel_t bsel;
  } dec_t;
  function automatic int e_max(input int w);
    return (1 << w) - 1;
  endfunction
  function automatic int fast_max(input int w);
    return e_max(w) - 3;
  endfunction
endpackage

// File: rtl/pre_map_decode.sv
// pre_map_decode: combinational region/sub-index decode into mode, sign, bias select and op.
module pre_map_decode
  import pre_map_pipe_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 32
) (
  input  logic [EXP_WIDTH-1:0]  exp_a,
  input  logic [FRAC_WIDTH-1:0] frac_a,
  input  logic                  p,
  output dec_t                  dec
);
  localparam logic [EXP_WIDTH-1:0] E_MAX  = EXP_WIDTH'(e_max(EXP_WIDTH));
  localparam logic [EXP_WIDTH-1:0] E_FAST = EXP_WIDTH'(fast_max(EXP_WIDTH));
  logic [1:0] q;
  assign q = frac_a[FRAC_WIDTH-2 -: 2];
  always_comb begin
    dec = '{fast: 1'b1, mode: 1'b0, sign: 1'b0, op: 1'b0, bsel: BS_NONE};
    if (exp_a > E_FAST) begin
      if (exp_a == E_MAX)
        case (q)
          2'd0:    dec = '{1'b0, 1'b0, 1'b1, 1'b0, BS_B2};
          2'd1:    dec = '{1'b0, 1'b1, 1'b1, 1'b1, BS_B3};
          2'd2:    dec = '{1'b0, 1'b1, ~p, 1'b0, BS_B3};
          default: dec = '{1'b0, 1'b0, ~p, 1'b1, BS_B4};
        endcase
      else if (exp_a == E_MAX - EXP_WIDTH'(1))
        dec = q[1] ? '{1'b0, 1'b0, p, 1'b1, BS_B2} : '{1'b0, 1'b1, p, 1'b0, BS_B1};
      else
        dec = '{1'b0, 1'b1, 1'b0, 1'b1, BS_B1};
    end
  end
endmodule

// File: rtl/pre_map_pipe.sv
// pre_map_pipe: two-stage operand pre-mapping pipeline (decode, bias select) with fast-path counter.
module pre_map_pipe
  import pre_map_pipe_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_sign_a,
  input  logic [EXP_WIDTH-1:0]  i_exp_a,
  input  logic [FRAC_WIDTH-1:0] i_frac_a,
  input  logic                  i_sincos_proced,
  input  logic                  i_result_sign_flip,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  input  logic                  i_flush,
  input  logic                  i_cnt_clr,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sign_a,
  output logic [EXP_WIDTH-1:0]  o_exp_a,
  output logic [FRAC_WIDTH-1:0] o_frac_a,
  output logic                  o_sign_bias,
  output logic [EXP_WIDTH-1:0]  o_exp_bias,
  output logic [FRAC_WIDTH-1:0] o_frac_bias,
  output logic                  o_sincos_proced,
  output logic                  o_result_sign_flip,
  output logic                  o_fast_path,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic [CNT_WIDTH-1:0]  o_fast_cnt
);
  localparam logic [EXP_WIDTH-1:0]  E_MAX    = EXP_WIDTH'(e_max(EXP_WIDTH));
  localparam logic [EXP_WIDTH-1:0]  EXP_HALF = {1'b1, {(EXP_WIDTH-1){1'b0}}};
  localparam logic [FRAC_WIDTH-1:0] FRAC_MSB = {1'b1, {(FRAC_WIDTH-1){1'b0}}};
  localparam logic [FRAC_WIDTH-1:0] FRAC_TWO = {2'b11, {(FRAC_WIDTH-2){1'b0}}};
  dec_t                  dec, s1_dec;
  logic                  s1_v, s1_sign, s1_p, s1_flip, s2_load, in_hs;
  logic [EXP_WIDTH-1:0]  s1_exp, b_exp;
  logic [FRAC_WIDTH-1:0] s1_frac, b_frac;
  logic [TAG_WIDTH-1:0]  s1_tag;
  pre_map_decode #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_decode (
    .exp_a (i_exp_a),
    .frac_a(i_frac_a),
    .p     (i_sincos_proced),
    .dec   (dec)
  );
  assign s2_load = ~o_valid | i_ready;
  assign o_ready = ~i_flush & (~s1_v | s2_load);
  assign in_hs   = i_valid & o_ready;
  assign b_exp  = s1_dec.bsel == BS_B1 ? E_MAX - EXP_WIDTH'(1) :
                  (s1_dec.bsel == BS_B2 || s1_dec.bsel == BS_B3) ? E_MAX :
                  s1_dec.bsel == BS_B4 ? '0 : EXP_HALF;
  assign b_frac = s1_dec.bsel == BS_NONE ? '0 : s1_dec.bsel == BS_B3 ? FRAC_TWO : FRAC_MSB;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_exp  <= '0;
      s1_frac <= '0;
      s1_p    <= 1'b0;
      s1_flip <= 1'b0;
      s1_tag  <= '0;
      s1_dec  <= '0;
    end else begin
      if (i_flush) s1_v <= 1'b0;
      else if (o_ready) s1_v <= i_valid;
      if (in_hs) begin
        s1_sign <= i_sign_a;
        s1_exp  <= i_exp_a;
        s1_frac <= i_frac_a;
        s1_p    <= i_sincos_proced;
        s1_flip <= i_result_sign_flip;
        s1_tag  <= i_tag;
        s1_dec  <= dec;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid            <= 1'b0;
      o_sign_a           <= 1'b0;
      o_exp_a            <= '0;
      o_frac_a           <= '0;
      o_sign_bias        <= 1'b0;
      o_exp_bias         <= '0;
      o_frac_bias        <= '0;
      o_sincos_proced    <= 1'b0;
      o_result_sign_flip <= 1'b0;
      o_fast_path        <= 1'b0;
      o_tag              <= '0;
    end else begin
      if (i_flush) o_valid <= 1'b0;
      else if (s2_load) o_valid <= s1_v;
      if (s2_load && s1_v && !i_flush) begin
        o_sign_a           <= s1_sign ^ s1_dec.op;
        o_exp_a            <= s1_exp;
        o_frac_a           <= s1_frac;
        o_sign_bias        <= ~s1_dec.fast & ~s1_dec.op;
        o_exp_bias         <= b_exp;
        o_frac_bias        <= b_frac;
        o_sincos_proced    <= s1_p ^ s1_dec.mode;
        o_result_sign_flip <= s1_flip ^ s1_dec.sign;
        o_fast_path        <= s1_dec.fast;
        o_tag              <= s1_tag;
      end
    end
  end
  // clear wins over a same-cycle delivery; flushed cycles never count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_fast_cnt <= '0;
    else if (i_cnt_clr) o_fast_cnt <= '0;
    else if (o_valid && i_ready && !i_flush && o_fast_path && !(&o_fast_cnt)) o_fast_cnt <= o_fast_cnt + 1'b1;
  end
endmodule
